// File: rtl/te_radio_seq.sv
// Per-lane radio enable/rx-enable sequencer with input synchronizers.
// Optional sticky sequencing-error flags under TE_RADIO_SEQ_STATUS_EN.
module te_radio_seq #(
  parameter int BIT_WIDTH     = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 ck,
  input  logic                 arst_n,
  input  logic                 isolateM1M3,
  input  logic [BIT_WIDTH-1:0] radioEnableReq,
  input  logic [BIT_WIDTH-1:0] radioRxEnReq,
  output logic [BIT_WIDTH-1:0] radioEnableSynced,
  output logic [BIT_WIDTH-1:0] radioRxEnSynced
`ifdef TE_RADIO_SEQ_STATUS_EN
  ,
  output logic [BIT_WIDTH-1:0] seqErr
`endif
);

  typedef enum logic [2:0] {
    OFF,
    SETTLE,
    ON,
    RX,
    DROP
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [BIT_WIDTH-1:0] en_sync [SYNC_STAGES];
  logic [BIT_WIDTH-1:0] rx_sync [SYNC_STAGES];
  logic [BIT_WIDTH-1:0] en_s;
  logic [BIT_WIDTH-1:0] rx_s;

  state_t     st_q  [BIT_WIDTH];
  state_t     st_d  [BIT_WIDTH];
  logic [7:0] cnt_q [BIT_WIDTH];
  logic [7:0] cnt_d [BIT_WIDTH];

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        en_sync[i] <= '0;
        rx_sync[i] <= '0;
      end
    end else begin
      en_sync[0] <= radioEnableReq;
      rx_sync[0] <= radioRxEnReq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        en_sync[i] <= en_sync[i-1];
        rx_sync[i] <= rx_sync[i-1];
      end
    end
  end

  assign en_s = en_sync[SYNC_STAGES-1];
  assign rx_s = rx_sync[SYNC_STAGES-1];

  // rx_s without en_s is never a transition cause
  always_comb begin
    for (int l = 0; l < BIT_WIDTH; l++) begin
      st_d[l]  = st_q[l];
      cnt_d[l] = cnt_q[l];
      if (isolateM1M3) begin
        st_d[l]  = OFF;
        cnt_d[l] = '0;
      end else begin
        unique case (st_q[l])
          OFF: begin
            if (en_s[l]) begin
              st_d[l]  = SETTLE;
              cnt_d[l] = SETTLE_LOAD;
            end
          end
          SETTLE: begin
            if (!en_s[l]) begin
              st_d[l]  = OFF;
              cnt_d[l] = '0;
            end else if (cnt_q[l] == 8'd0) begin
              st_d[l] = ON;
            end else begin
              cnt_d[l] = cnt_q[l] - 8'd1;
            end
          end
          ON: begin
            if (!en_s[l])
              st_d[l] = OFF;
            else if (rx_s[l])
              st_d[l] = RX;
          end
          RX: begin
            if (!en_s[l])
              st_d[l] = DROP;
            else if (!rx_s[l])
              st_d[l] = ON;
          end
          DROP:    st_d[l] = OFF;
          default: st_d[l] = OFF;
        endcase
      end
    end
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      for (int l = 0; l < BIT_WIDTH; l++) begin
        st_q[l]  <= OFF;
        cnt_q[l] <= '0;
      end
      radioEnableSynced <= '0;
      radioRxEnSynced   <= '0;
    end else begin
      for (int l = 0; l < BIT_WIDTH; l++) begin
        st_q[l]              <= st_d[l];
        cnt_q[l]             <= cnt_d[l];
        radioEnableSynced[l] <= (st_d[l] != OFF);
        radioRxEnSynced[l]   <= (st_d[l] == RX);
      end
    end
  end

`ifdef TE_RADIO_SEQ_STATUS_EN
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n)
      seqErr <= '0;
    else
      seqErr <= seqErr | (rx_s & ~en_s);
  end
`endif

endmodule
